// File: rtl/calc_pkg.sv
// Shared types for the calculator controller: op encoding, FSM states, latched request.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_EXEC,
    S_DIV_ISSUE,
    S_DIV_WAIT,
    S_DONE
  } state_e;

  localparam logic [15:0] ERR_RESULT = 16'hFFFF;

  // Button vector layout; index 0 is the clear/abort button.
  localparam int NUM_BTN = 5;
  localparam int BTN_CLR = 0;

  typedef struct packed {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
  } op_req_t;

  // rise[0]=ADD, [1]=SUB, [2]=MUL, [3]=DIV; lowest index wins.
  function automatic op_e pick_op(input logic [3:0] rise);
    if (rise[0])      pick_op = OP_ADD;
    else if (rise[1]) pick_op = OP_SUB;
    else if (rise[2]) pick_op = OP_MUL;
    else              pick_op = OP_DIV;
  endfunction

endpackage

// File: rtl/calc_ctrl_btn_cond.sv
// Button conditioner: 2-flop sync, optional debounce (CALC_DEBOUNCE_EN), registered rising-edge pulse.
module btn_cond #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       prev_q;
  logic       rise_q;

  // Everything resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], btn_i};
  end

`ifdef CALC_DEBOUNCE_EN
  logic [15:0] cnt_q;
  logic        lvl_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else if (sync_q[1] == lvl_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
      lvl_q <= sync_q[1];
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync_q[1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      prev_q <= lvl;
      rise_q <= lvl & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: button edges drive a latch/execute FSM with an AXI-stream divider path.
// Optional debounce on every button when CALC_DEBOUNCE_EN is defined.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          DIV_TIMEOUT     = 64
) (
  input  logic        CLK100MHZ,
  input  logic        RESET,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        BTN_ADD,
  input  logic        BTN_SUB,
  input  logic        BTN_MUL,
  input  logic        BTN_DIV,
  input  logic        BTNC,
  output logic [7:0]  opa,
  output logic [7:0]  opb,
  output op_e         op_sel,
  input  logic [8:0]  add_res,
  input  logic [8:0]  sub_res,
  input  logic [15:0] mul_res,
  output logic        div_tvalid,
  input  logic        div_tready,
  input  logic        div_dout_tvalid,
  input  logic [15:0] div_dout_tdata,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] rise;

  assign btn_raw = {BTN_DIV, BTN_MUL, BTN_SUB, BTN_ADD, BTNC};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk_i (CLK100MHZ),
      .rst_i (RESET),
      .btn_i (btn_raw[i]),
      .rise_o(rise[i])
    );
  end

  state_e          state_q, state_d;
  op_req_t         lat_q, lat_d;
  op_e             pend_q, pend_d;
  logic [15:0]     result_q, result_d;
  logic            err_q, err_d;
  logic            tvalid_q, tvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic clr;
  logic op_vld;

  assign clr    = rise[BTN_CLR];
  assign op_vld = |rise[NUM_BTN-1:1];

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      pend_q   <= OP_ADD;
      result_q <= '0;
      err_q    <= 1'b0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      err_q    <= err_d;
      tvalid_q <= tvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    pend_d   = pend_q;
    result_d = result_q;
    err_d    = err_q;
    tvalid_d = tvalid_q;
    cnt_d    = cnt_q;

    if (clr) begin
      state_d  = S_IDLE;
      result_d = '0;
      err_d    = 1'b0;
      tvalid_d = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Edges arriving in any other state are simply dropped.
          if (op_vld) begin
            pend_d  = pick_op(rise[NUM_BTN-1:1]);
            state_d = S_LATCH;
          end
        end
        S_LATCH: begin
          lat_d = '{op: pend_q, a: A, b: B};
          cnt_d = '0;
          if (pend_q != OP_DIV) begin
            state_d = S_EXEC;
          end else if (B != 8'd0) begin
            tvalid_d = 1'b1;
            state_d  = S_DIV_ISSUE;
          end else begin
            result_d = ERR_RESULT;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_EXEC: begin
          unique case (lat_q.op)
            OP_ADD:  result_d = {7'd0, add_res};
            OP_SUB:  result_d = {{7{sub_res[8]}}, sub_res};
            default: result_d = mul_res;
          endcase
          err_d   = 1'b0;
          state_d = S_DONE;
        end
        S_DIV_ISSUE: begin
          if (div_tready) begin
            tvalid_d = 1'b0;
            state_d  = S_DIV_WAIT;
          end
        end
        S_DIV_WAIT: begin
          if (div_dout_tvalid) begin
            result_d = div_dout_tdata;
            err_d    = 1'b0;
            state_d  = S_DONE;
          end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
            result_d = ERR_RESULT;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign opa        = lat_q.a;
  assign opb        = lat_q.b;
  assign op_sel     = lat_q.op;
  assign div_tvalid = tvalid_q;
  assign result     = result_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);
  // An abort landing on the DONE cycle suppresses the pulse.
  assign done       = (state_q == S_DONE) && !clr;

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, stable cycles required before the debounced button level changes.
REQ-002 SHALL have parameter DIV_TIMEOUT, default 64, maximum DIV_WAIT cycles before a divide is abandoned.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: CLK100MHZ  in  1  system clock; RESET  in  1  async active-high reset.
REQ-004 SHALL have ports A, B  in  8  raw operands; BTN_ADD, BTN_SUB, BTN_MUL, BTN_DIV, BTNC  in  1  raw buttons (BTNC = clear/abort).
REQ-005 SHALL have ports opa, opb  out  8  latched operands to datapath; op_sel  out  2  latched op (calc_pkg::op_e).
REQ-006 SHALL have ports add_res  in  9; sub_res  in  9 (two's complement); mul_res  in  16  datapath results for opa/opb.
REQ-007 SHALL have ports div_tvalid  out  1; div_tready  in  1; div_dout_tvalid  in  1; div_dout_tdata  in  16  divider AXI-stream handshake.
REQ-008 SHALL have ports result  out  16; busy  out  1; done  out  1 (single-cycle pulse); err  out  1 (sticky).

Function
REQ-009 SHALL synchronize each button through 2 flops, then detect rising edges only; levels held high never retrigger.
REQ-010 SHALL resolve simultaneous edges by priority BTNC > ADD > SUB > MUL > DIV.
REQ-011 SHALL implement FSM states IDLE, LATCH, EXEC, DIV_ISSUE, DIV_WAIT, DONE.
REQ-012 In IDLE, an op edge SHALL go to LATCH; LATCH captures A->opa, B->opb, op->op_sel, then goes to EXEC (ADD/SUB/MUL) or DIV_ISSUE (DIV, opb!=0).
REQ-013 EXEC SHALL register result (add_res zero-extended, sub_res sign-extended, mul_res direct), clear err, and go to DONE.
REQ-014 DIV_ISSUE SHALL hold div_tvalid=1 until the cycle div_tready=1, then go to DIV_WAIT; div_tvalid drops the following cycle.
REQ-015 DIV_WAIT SHALL capture div_dout_tdata into result on div_dout_tvalid=1, clear err, and go to DONE; after DIV_TIMEOUT cycles without it, result=16'hFFFF, err=1, go to DONE.
REQ-016 DIV with opb==0 SHALL skip the divider (div_tvalid never asserted): result=16'hFFFF, err=1, go to DONE.
REQ-017 DONE SHALL pulse done for exactly one cycle and return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE; op edges while busy SHALL be discarded, not queued.
REQ-019 BTNC edge in any state SHALL abort: result=0, err=0, div_tvalid=0, no done pulse, next state IDLE.
REQ-020 Latency without debounce: button first sampled high at edge k -> result/done valid after edge k+5 for ADD/SUB/MUL.
REQ-021 A change on A/B after LATCH SHALL NOT affect the in-flight operation.

Reset
REQ-022 RESET SHALL asynchronously force state IDLE; result, opa, opb, op_sel, div_tvalid, busy, done, err to 0; timeout counter to 0.
REQ-023 Synchronizer, debounce and edge-history flops SHALL reset to 1 so buttons held through reset produce no edge.
REQ-024 Reset asserted mid-divide SHALL drop div_tvalid immediately; a late div_dout_tvalid after reset SHALL be ignored in IDLE.

Configuration
REQ-025 Macro CALC_DEBOUNCE_EN defined: each synchronized button changes debounced level only after DEBOUNCE_CYCLES consecutive equal samples; latency grows by DEBOUNCE_CYCLES.
REQ-026 CALC_DEBOUNCE_EN undefined: no debounce logic, DEBOUNCE_CYCLES ignored, REQ-020 latency applies.

Structure
REQ-027 Package calc_pkg SHALL hold op_e (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3), the FSM state enum, and ERR_RESULT=16'hFFFF.
REQ-028 Sub-module btn_cond (sync, optional debounce, rising-edge pulse) SHALL be instantiated once per button.

Verification
REQ-029 A=8'd200, B=8'd100, pulse BTN_ADD -> op_sel=OP_ADD, result=16'd300, done one cycle, err=0.
REQ-030 A=8'd5, B=8'd9, BTN_SUB -> result=16'hFFFC; then BTN_MUL with A=8'd255, B=8'd255 -> result=16'hFE01.
REQ-031 A=8'd100, B=8'd7, BTN_DIV, div_tready after 3 cycles, dout_tvalid after 20 with 16'h0E02 -> result=16'h0E02, div_tvalid high exactly until handshake.
REQ-032 BTN_DIV with B=0 -> div_tvalid never high, result=16'hFFFF, err=1; then BTN_ADD A=1, B=1 -> result=2, err=0.
REQ-033 BTN_DIV, divider never returns -> err=1, result=16'hFFFF after DIV_TIMEOUT; repeat with BTNC mid-DIV_WAIT -> result=0, no done.
REQ-034 BTN_ADD and BTN_MUL rising same cycle -> ADD executed; BTN_SUB pressed while busy -> ignored; button held through RESET -> no operation.
